// File: rtl/parity_stream_codec_if.sv
// Bundle of the encoder and checker channels of parity_stream_codec.
// The master side belongs to the producer/deframer and the slave side to the codec.
interface parity_stream_codec_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              odd_mode;
  logic              gen_valid;
  logic              gen_ready;
  logic [DATA_W-1:0] gen_data;
  logic              enc_valid;
  logic              enc_ready;
  logic [DATA_W:0]   enc_data;
  logic              chk_valid;
  logic [DATA_W:0]   chk_data;
  logic              chk_ok;
  logic              chk_err;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_count;
  logic              clr_err;

  modport master (
    output odd_mode, gen_valid, gen_data, enc_ready, chk_valid, chk_data, clr_err,
    input  gen_ready, enc_valid, enc_data, chk_ok, chk_err, err_sticky, err_count
  );

  modport slave (
    input  odd_mode, gen_valid, gen_data, enc_ready, chk_valid, chk_data, clr_err,
    output gen_ready, enc_valid, enc_data, chk_ok, chk_err, err_sticky, err_count
  );
endinterface

// File: rtl/parity_stream_codec.sv
// Parity encoder (one-entry valid/ready register, parity appended as MSB)
// and an independent parity checker with sticky flag and saturating error count.
module parity_stream_codec #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_stream_codec_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              enc_valid_reg;
  logic [DATA_W:0]   enc_data_reg;
  logic              chk_ok_reg;
  logic              chk_err_reg;
  logic              err_sticky_reg;
  logic              err_sticky_next;
  logic [CNT_W-1:0]  err_count_reg;
  logic [CNT_W-1:0]  err_count_next;
  logic [CNT_W-1:0]  count_base;
  logic              accept;
  logic              chk_good;
  logic              chk_bad;

  assign bus.gen_ready = rst_n & (!enc_valid_reg | bus.enc_ready);
  assign accept        = bus.gen_valid & bus.gen_ready;

  assign chk_good = ((^bus.chk_data) == bus.odd_mode);
  assign chk_bad  = bus.chk_valid & !chk_good;

  // A clear and an error on the same edge: the clear applies first, then the error counts.
  always_comb begin
    count_base      = bus.clr_err ? '0 : err_count_reg;
    err_count_next  = count_base;
    err_sticky_next = bus.clr_err ? 1'b0 : err_sticky_reg;
    if (chk_bad) begin
      err_sticky_next = 1'b1;
      if (count_base != CNT_MAX) begin
        err_count_next = CNT_W'(count_base + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_valid_reg  <= 1'b0;
      enc_data_reg   <= '0;
      chk_ok_reg     <= 1'b0;
      chk_err_reg    <= 1'b0;
      err_sticky_reg <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      if (accept) begin
        enc_valid_reg <= 1'b1;
        enc_data_reg  <= {(^bus.gen_data) ^ bus.odd_mode, bus.gen_data};
      end else if (bus.enc_ready) begin
        enc_valid_reg <= 1'b0;
      end
      chk_ok_reg     <= bus.chk_valid & chk_good;
      chk_err_reg    <= chk_bad;
      err_sticky_reg <= err_sticky_next;
      err_count_reg  <= err_count_next;
    end
  end

  assign bus.enc_valid  = enc_valid_reg;
  assign bus.enc_data   = enc_data_reg;
  assign bus.chk_ok     = chk_ok_reg;
  assign bus.chk_err    = chk_err_reg;
  assign bus.err_sticky = err_sticky_reg;
  assign bus.err_count  = err_count_reg;

endmodule

// File: tb/tb_parity_stream_codec.sv
// Directed bench for parity_stream_codec (DATA_W=8, CNT_W=2) with hand-computed expectations.
module tb_parity_stream_codec;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  parity_stream_codec_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  parity_stream_codec #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  t1_in  [5] = '{8'h03, 8'h0B, 8'h00, 8'h07, 8'hFF};
  logic [8:0]  t1_out [5] = '{9'h003, 9'h10B, 9'h000, 9'h107, 9'h0FF};
  logic [1:0]  t5_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    total = 0;
    bad   = 0;
    rst_n          = 1'b0;
    bus.odd_mode   = 1'b0;
    bus.gen_valid  = 1'b0;
    bus.gen_data   = '0;
    bus.enc_ready  = 1'b0;
    bus.chk_valid  = 1'b0;
    bus.chk_data   = '0;
    bus.clr_err    = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_enc_valid", 32'(bus.enc_valid), 32'd0);
    check("rst_enc_data", 32'(bus.enc_data), 32'd0);
    check("rst_gen_ready", 32'(bus.gen_ready), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    check("rst_chk_ok_err", 32'({bus.chk_ok, bus.chk_err, bus.err_sticky}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_gen_ready", 32'(bus.gen_ready), 32'd1);

    // 1: even mode streaming
    bus.enc_ready = 1'b1;
    bus.gen_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.gen_data = t1_in[i];
      tick();
      check($sformatf("t1_valid_%0d", i), 32'(bus.enc_valid), 32'd1);
      check($sformatf("t1_data_%0d", i), 32'(bus.enc_data), 32'(t1_out[i]));
    end
    bus.gen_valid = 1'b0;
    tick();
    check("t1_drain_valid", 32'(bus.enc_valid), 32'd0);

    // 2: odd mode, then toggle mode while a word is held
    bus.odd_mode  = 1'b1;
    bus.gen_valid = 1'b1;
    bus.gen_data  = 8'h00;
    tick();
    check("t2_data_00", 32'(bus.enc_data), 32'h100);
    bus.gen_data = 8'h0B;
    tick();
    check("t2_data_0b", 32'(bus.enc_data), 32'h00B);
    bus.gen_valid = 1'b0;
    bus.enc_ready = 1'b0;
    bus.odd_mode  = 1'b0;
    tick();
    check("t2_hold_data", 32'(bus.enc_data), 32'h00B);
    check("t2_hold_valid", 32'(bus.enc_valid), 32'd1);
    check("t2_hold_gen_ready", 32'(bus.gen_ready), 32'd0);
    bus.enc_ready = 1'b1;
    tick();
    check("t2_drained", 32'(bus.enc_valid), 32'd0);

    // 3: backpressure, even mode
    bus.enc_ready = 1'b0;
    bus.gen_valid = 1'b1;
    bus.gen_data  = 8'h03;
    tick();
    check("t3_first", 32'(bus.enc_data), 32'h003);
    bus.gen_data = 8'h0B;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("t3_hold_data_%0d", i), 32'(bus.enc_data), 32'h003);
      check($sformatf("t3_hold_ready_%0d", i), 32'(bus.gen_ready), 32'd0);
    end
    bus.enc_ready = 1'b1;
    #1;
    check("t3_ready_up", 32'(bus.gen_ready), 32'd1);
    tick();
    check("t3_second_data", 32'(bus.enc_data), 32'h10B);
    check("t3_second_valid", 32'(bus.enc_valid), 32'd1);
    bus.gen_valid = 1'b0;
    tick();
    check("t3_no_dup", 32'(bus.enc_valid), 32'd0);

    // 4: checker
    bus.chk_valid = 1'b1;
    bus.chk_data  = 9'h10B;
    tick();
    check("t4_good_okerr", 32'({bus.chk_ok, bus.chk_err}), 32'b10);
    check("t4_good_count", 32'(bus.err_count), 32'd0);
    bus.chk_data = 9'h00B;
    tick();
    check("t4_bad_okerr", 32'({bus.chk_ok, bus.chk_err}), 32'b01);
    check("t4_bad_sticky", 32'(bus.err_sticky), 32'd1);
    check("t4_bad_count", 32'(bus.err_count), 32'd1);
    bus.odd_mode = 1'b1;
    tick();
    check("t4_odd_okerr", 32'({bus.chk_ok, bus.chk_err}), 32'b10);
    check("t4_odd_count", 32'(bus.err_count), 32'd1);
    bus.chk_valid = 1'b0;
    tick();
    check("t4_idle_okerr", 32'({bus.chk_ok, bus.chk_err}), 32'b00);

    // 5: saturation and clear interplay
    bus.odd_mode = 1'b0;
    bus.clr_err  = 1'b1;
    tick();
    check("t5_pre_clear", 32'({bus.err_sticky, bus.err_count}), 32'd0);
    bus.clr_err   = 1'b0;
    bus.chk_valid = 1'b1;
    bus.chk_data  = 9'h00B;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_count_%0d", i), 32'(bus.err_count), 32'(t5_cnt[i]));
    end
    bus.clr_err = 1'b1;
    tick();
    check("t5_clr_with_err_count", 32'(bus.err_count), 32'd1);
    check("t5_clr_with_err_sticky", 32'(bus.err_sticky), 32'd1);
    bus.chk_valid = 1'b0;
    tick();
    check("t5_clr_alone", 32'({bus.err_sticky, bus.err_count}), 32'd0);
    bus.clr_err = 1'b0;

    // 6: reset while a word is held and count=2, with encoder and checker both active
    bus.enc_ready = 1'b0;
    bus.gen_valid = 1'b1;
    bus.gen_data  = 8'h07;
    bus.chk_valid = 1'b1;
    bus.chk_data  = 9'h00B;
    tick();
    bus.gen_valid = 1'b0;
    check("t6_enc_during_chk", 32'(bus.enc_data), 32'h107);
    tick();
    check("t6_setup_count", 32'(bus.err_count), 32'd2);
    check("t6_setup_valid", 32'(bus.enc_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_gen_ready_in_rst", 32'(bus.gen_ready), 32'd0);
    tick();
    check("t6_enc_valid", 32'(bus.enc_valid), 32'd0);
    check("t6_err_count", 32'(bus.err_count), 32'd0);
    check("t6_chk_okerr", 32'({bus.chk_ok, bus.chk_err}), 32'b00);
    rst_n         = 1'b1;
    bus.chk_valid = 1'b0;
    #1;
    check("t6_gen_ready_after", 32'(bus.gen_ready), 32'd1);
    tick();
    check("t6_not_represented", 32'(bus.enc_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_stream_codec.md
Name: parity_stream_codec

Overview:
Parametrised successor to the team's 4-bit combinational parity generator. It has two independent channels:
- Encoder: a registered, valid/ready-handshaked stage that appends a parity bit as MSB, giving {parity, data}.
- Checker: verifies incoming {parity, data} words and keeps an error flag and an error count.
Even or odd parity is selected at run time. The block sits between a data producer and a serial/link framer, and on the receive side after the deframer.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CNT_W, 8, error counter width in bits (>=1)

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
odd_mode  in  1  0 = even parity, 1 = odd parity; applies to both channels
gen_valid  in  1  encoder input word valid
gen_ready  out  1  encoder can accept a word
gen_data  in  DATA_W  encoder payload
enc_valid  out  1  encoded word valid
enc_ready  in  1  downstream accepts encoded word
enc_data  out  DATA_W+1  {parity, payload}
chk_valid  in  1  checker input valid (no backpressure)
chk_data  in  DATA_W+1  {parity, payload} to check
chk_ok  out  1  one-cycle pulse: checked word good
chk_err  out  1  one-cycle pulse: checked word bad
err_sticky  out  1  set on any checker error until cleared
err_count  out  CNT_W  saturating checker error count
clr_err  in  1  synchronous clear of err_sticky and err_count

Behaviour:
Reset:
- Reset is synchronous, active-low: on any clk edge with rst_n=0, enc_valid, enc_data, chk_ok, chk_err, err_sticky and err_count go to 0.
- gen_ready=0 while rst_n=0.
- Reset mid-transfer drops the held encoded word; it is not re-presented.

Parity rule:
- P = XOR of all payload bits, XOR odd_mode.
- Even mode: the total count of ones in {P, payload} is even. Odd mode: it is odd.

Encoder (one-entry pipeline register):
- gen_ready = rst_n & (!enc_valid | enc_ready), combinational.
- Accept when gen_valid & gen_ready: next cycle enc_valid=1 and enc_data={P, gen_data}.
- odd_mode is sampled at accept; a later change does not alter a held word.
- If enc_valid & !enc_ready: enc_data and enc_valid hold stable and gen_ready=0.
- If enc_ready with no new accept: enc_valid goes 0; enc_data may keep its stale value.
- Simultaneous drain and accept: enc_valid stays 1 with the new word. This sustains 1 word/cycle.
- Latency: exactly 1 cycle from accept to enc_valid.

Checker:
- Sample when chk_valid=1. Good when the XOR of all DATA_W+1 bits equals odd_mode.
- Result appears on the next cycle: chk_ok=1 if good, chk_err=1 if bad.
- Both outputs are 0 in cycles following no chk_valid. They are never both 1.
- Error count is updated on the same edge chk_err is registered:
  - err_sticky goes to 1.
  - err_count increments, saturating at 2^CNT_W-1 with no wrap.
- clr_err alone: err_sticky=0, err_count=0 next cycle.
- clr_err in the same cycle an error is being registered: the error wins after the clear, giving err_sticky=1 and err_count=1.
- The checker and encoder are fully independent; simultaneous activity must not interact.

Test Plan:
1. Even mode, DATA_W=8, enc_ready=1; gen_data 0x03, 0x0B, 0x00, 0x07, 0xFF on consecutive cycles -> enc_data 0x003, 0x10B, 0x000, 0x107, 0x0FF, each one cycle after accept, enc_valid continuous for 5 cycles.
2. Odd mode; gen_data 0x00 then 0x0B -> enc_data 0x100 then 0x00B. Toggle odd_mode while a word is held (enc_ready=0) -> held enc_data unchanged.
3. Backpressure: hold enc_ready=0 and offer 0x03 then 0x0B -> enc_data stays 0x003 and gen_ready=0. Then raise enc_ready -> 0x10B follows next cycle with no word lost or duplicated.
4. Checker, even mode: chk_data 0x10B -> chk_ok pulse, err_count 0. Then chk_data 0x00B -> chk_err pulse, err_sticky=1, err_count=1. Then switch to odd mode with 0x00B -> chk_ok.
5. CNT_W=2: 5 back-to-back bad words -> err_count 1, 2, 3, 3, 3. Then clr_err together with a bad word -> err_count=1, err_sticky=1. Then clr_err alone -> both 0.
6. Drive rst_n=0 for one cycle while enc_valid=1, enc_ready=0 and err_count=2 -> next cycle enc_valid=0, err_count=0, chk_ok=chk_err=0, gen_ready=0 during reset and 1 after.
